// File: rtl/dram_read_arbiter.sv
// Two-requester round-robin read arbiter in front of a single Avalon-MM SDRAM read port.
// One burst is owned end to end: arbitrate in IDLE, issue in CMD, collect beats in DATA.
module dram_read_arbiter #(
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        req0_address,
    input  logic               req0_read,
    input  logic [BURST_W-1:0] req0_burst_count,
    output logic               req0_wait_request,
    output logic [31:0]        req0_read_data,
    output logic               req0_read_data_valid,

    input  logic [31:0]        req1_address,
    input  logic               req1_read,
    input  logic [BURST_W-1:0] req1_burst_count,
    output logic               req1_wait_request,
    output logic [31:0]        req1_read_data,
    output logic               req1_read_data_valid,

    output logic [31:0]        master_address,
    output logic               master_read,
    output logic [BURST_W-1:0] master_burst_count,
    input  logic [31:0]        master_read_data,
    input  logic               master_wait_request,
    input  logic               master_read_data_valid,

    output logic [1:0]         grant,
    output logic               busy,
    output logic               protocol_error
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [BURST_W-1:0] ZERO_BEATS = '0;
    localparam logic [BURST_W-1:0] ONE_BEAT   = {{(BURST_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [31:0]        r_address;
    logic [BURST_W-1:0] r_burst_count;
    logic [BURST_W-1:0] r_beats_left;
    logic [1:0]         r_grant;
    logic               r_last_served;
    logic               r_protocol_error;

    logic               w_req0_valid;
    logic               w_req1_valid;
    logic               w_req0_zero;
    logic               w_req1_zero;
    logic               w_pick_req1;
    logic               w_any_request;
    logic               w_beat_in_data;
    logic               w_final_beat;
    logic               w_stray_beat;

    assign w_req0_valid  = req0_read && (req0_burst_count != ZERO_BEATS);
    assign w_req1_valid  = req1_read && (req1_burst_count != ZERO_BEATS);
    assign w_req0_zero   = req0_read && (req0_burst_count == ZERO_BEATS);
    assign w_req1_zero   = req1_read && (req1_burst_count == ZERO_BEATS);
    assign w_any_request = w_req0_valid || w_req1_valid;

    // r_last_served is 1 when req1 owned the previous burst, so req0 wins the next tie.
    always_comb begin
        w_pick_req1 = 1'b0;
        if (w_req0_valid && w_req1_valid) begin
            w_pick_req1 = ~r_last_served;
        end else if (w_req1_valid) begin
            w_pick_req1 = 1'b1;
        end
    end

    assign w_beat_in_data = (r_state == ST_DATA) && master_read_data_valid;
    assign w_final_beat   = w_beat_in_data && (r_beats_left <= ONE_BEAT);
    assign w_stray_beat   = master_read_data_valid && (r_state != ST_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_address     <= 32'd0;
            r_burst_count <= ZERO_BEATS;
            r_beats_left  <= ZERO_BEATS;
            r_grant       <= 2'b00;
            r_last_served <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_request) begin
                        r_address     <= w_pick_req1 ? req1_address : req0_address;
                        r_burst_count <= w_pick_req1 ? req1_burst_count : req0_burst_count;
                        r_grant       <= w_pick_req1 ? 2'b10 : 2'b01;
                        r_state       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!master_wait_request) begin
                        r_beats_left <= r_burst_count;
                        r_state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // The requester's read line is ignored here: a started burst always drains.
                    if (w_beat_in_data && (r_beats_left != ZERO_BEATS)) begin
                        r_beats_left <= r_beats_left - ONE_BEAT;
                    end
                    if (w_final_beat) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= 2'b00;
                        r_last_served <= r_grant[1];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_protocol_error <= 1'b0;
        end else if (w_stray_beat) begin
            r_protocol_error <= 1'b1;
        end
    end

    // Wait-request: only a zero-length request in IDLE or the owner in CMD may see 0.
    always_comb begin
        req0_wait_request = 1'b1;
        req1_wait_request = 1'b1;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    req0_wait_request = ~w_req0_zero;
                    req1_wait_request = ~w_req1_zero;
                end
                ST_CMD: begin
                    if (r_grant[0]) begin
                        req0_wait_request = master_wait_request;
                    end
                    if (r_grant[1]) begin
                        req1_wait_request = master_wait_request;
                    end
                end
                default: begin
                    req0_wait_request = 1'b1;
                    req1_wait_request = 1'b1;
                end
            endcase
        end
    end

    assign req0_read_data       = master_read_data;
    assign req1_read_data       = master_read_data;
    assign req0_read_data_valid = w_beat_in_data && r_grant[0];
    assign req1_read_data_valid = w_beat_in_data && r_grant[1];

    assign master_read        = (r_state == ST_CMD);
    assign master_address     = r_address;
    assign master_burst_count = r_burst_count;

    assign grant          = r_grant;
    assign busy           = (r_state != ST_IDLE);
    assign protocol_error = r_protocol_error;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed bench for dram_read_arbiter: a beat scoreboard per requester plus
// cycle-exact checks of the command handshake, arbitration order and error flag.
module tb_dram_read_arbiter;

    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        req0_address, req1_address;
    logic               req0_read, req1_read;
    logic [BURST_W-1:0] req0_burst_count, req1_burst_count;
    logic               req0_wait_request, req1_wait_request;
    logic [31:0]        req0_read_data, req1_read_data;
    logic               req0_read_data_valid, req1_read_data_valid;
    logic [31:0]        master_address;
    logic               master_read;
    logic [BURST_W-1:0] master_burst_count;
    logic [31:0]        master_read_data;
    logic               master_wait_request;
    logic               master_read_data_valid;
    logic [1:0]         grant;
    logic               busy;
    logic               protocol_error;

    int nAssert = 0;
    int nFail   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    dram_read_arbiter #(.BURST_W(BURST_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req0_address           (req0_address),
        .req0_read              (req0_read),
        .req0_burst_count       (req0_burst_count),
        .req0_wait_request      (req0_wait_request),
        .req0_read_data         (req0_read_data),
        .req0_read_data_valid   (req0_read_data_valid),
        .req1_address           (req1_address),
        .req1_read              (req1_read),
        .req1_burst_count       (req1_burst_count),
        .req1_wait_request      (req1_wait_request),
        .req1_read_data         (req1_read_data),
        .req1_read_data_valid   (req1_read_data_valid),
        .master_address         (master_address),
        .master_read            (master_read),
        .master_burst_count     (master_burst_count),
        .master_read_data       (master_read_data),
        .master_wait_request    (master_wait_request),
        .master_read_data_valid (master_read_data_valid),
        .grant                  (grant),
        .busy                   (busy),
        .protocol_error         (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic [31:0] a0, input logic [BURST_W-1:0] b0,
                                 input logic r1, input logic [31:0] a1, input logic [BURST_W-1:0] b1);
        req0_read = r0; req0_address = a0; req0_burst_count = b0;
        req1_read = r1; req1_address = a1; req1_burst_count = b1;
        #1;
    endtask

    // Drives n back-to-back beats to requester `who`, queuing each one as expected data.
    task automatic sendBurst(input int who, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            master_read_data       = base + 32'(i);
            master_read_data_valid = 1'b1;
            if (who == 0) q0.push_back(base + 32'(i));
            else          q1.push_back(base + 32'(i));
            #1;
            checkOutput("busy_in_data", busy, 1'b1);
            step();
        end
        master_read_data_valid = 1'b0;
        #1;
    endtask

    // Every delivered beat must match the oldest expected beat of that requester.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (req0_read_data_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checkOutput("r0_valid_unexpected", req0_read_data_valid, 1'b0);
            end else begin
                exp = q0.pop_front();
                checkOutput("r0_data", req0_read_data, exp);
                checkOutput("r1_data_bcast", req1_read_data, exp);
            end
        end
        if (req1_read_data_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("r1_valid_unexpected", req1_read_data_valid, 1'b0);
            end else begin
                exp = q1.pop_front();
                checkOutput("r1_data", req1_read_data, exp);
                checkOutput("r0_data_bcast", req0_read_data, exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        master_read_data = 32'd0;
        master_wait_request = 1'b0;
        master_read_data_valid = 1'b0;
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        step();
        step();

        // Reset values, including a zero-length request that must still stall.
        applyStimulus(1'b1, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        checkOutput("rst_master_read", master_read, 1'b0);
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_perr", protocol_error, 1'b0);
        checkOutput("rst_r0_wait", req0_wait_request, 1'b1);
        checkOutput("rst_r1_wait", req1_wait_request, 1'b1);
        checkOutput("rst_r0_valid", req0_read_data_valid, 1'b0);
        checkOutput("rst_r1_valid", req1_read_data_valid, 1'b0);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        rst = 1'b0;
        step();

        // Single burst with two stalled command cycles.
        master_wait_request = 1'b1;
        applyStimulus(1'b1, 32'h1000, 8'd8, 1'b0, 32'd0, 8'd0);
        checkOutput("t1_idle_r0_wait", req0_wait_request, 1'b1);
        checkOutput("t1_idle_mread", master_read, 1'b0);
        step();
        checkOutput("t1_cmd1_mread", master_read, 1'b1);
        checkOutput("t1_cmd1_addr", master_address, 32'h1000);
        checkOutput("t1_cmd1_count", master_burst_count, 8'd8);
        checkOutput("t1_cmd1_grant", grant, 2'b01);
        checkOutput("t1_cmd1_busy", busy, 1'b1);
        checkOutput("t1_cmd1_r0_wait", req0_wait_request, 1'b1);
        checkOutput("t1_cmd1_r1_wait", req1_wait_request, 1'b1);
        step();
        checkOutput("t1_cmd2_mread", master_read, 1'b1);
        checkOutput("t1_cmd2_r0_wait", req0_wait_request, 1'b1);
        step();
        master_wait_request = 1'b0;
        #1;
        checkOutput("t1_cmd3_mread", master_read, 1'b1);
        checkOutput("t1_accept_r0_wait", req0_wait_request, 1'b0);
        checkOutput("t1_accept_r1_wait", req1_wait_request, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        checkOutput("t1_data_mread", master_read, 1'b0);
        checkOutput("t1_data_grant", grant, 2'b01);
        sendBurst(0, 8, 32'hA000_0000);
        checkOutput("t1_end_busy", busy, 1'b0);
        checkOutput("t1_end_grant", grant, 2'b00);

        // Contention after reset: req0 first, then req1, then req0 again.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        applyStimulus(1'b1, 32'h2000, 8'd4, 1'b1, 32'h3000, 8'd4);
        checkOutput("t2_idle_r0_wait", req0_wait_request, 1'b1);
        checkOutput("t2_idle_r1_wait", req1_wait_request, 1'b1);
        step();
        checkOutput("t2_first_grant", grant, 2'b01);
        checkOutput("t2_first_addr", master_address, 32'h2000);
        checkOutput("t2_first_r0_wait", req0_wait_request, 1'b0);
        checkOutput("t2_first_r1_wait", req1_wait_request, 1'b1);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 32'h3000, 8'd4);
        step();
        checkOutput("t2_data_r1_wait", req1_wait_request, 1'b1);
        sendBurst(0, 4, 32'hB000_0000);
        checkOutput("t2_gap_grant", grant, 2'b00);
        checkOutput("t2_gap_busy", busy, 1'b0);
        checkOutput("t2_gap_mread", master_read, 1'b0);
        step();
        checkOutput("t2_second_grant", grant, 2'b10);
        checkOutput("t2_second_addr", master_address, 32'h3000);
        checkOutput("t2_second_count", master_burst_count, 8'd4);
        checkOutput("t2_second_r1_wait", req1_wait_request, 1'b0);
        checkOutput("t2_second_r0_wait", req0_wait_request, 1'b1);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        step();
        sendBurst(1, 4, 32'hC000_0000);
        checkOutput("t2_second_end_grant", grant, 2'b00);
        applyStimulus(1'b1, 32'h2100, 8'd4, 1'b1, 32'h3100, 8'd4);
        step();
        checkOutput("t2_third_grant", grant, 2'b01);
        checkOutput("t2_third_addr", master_address, 32'h2100);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        step();
        sendBurst(0, 4, 32'hD000_0000);
        checkOutput("t2_third_end_busy", busy, 1'b0);

        // Zero-length request is acknowledged but never forwarded.
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 32'h3000, 8'd0);
        checkOutput("t3_r1_wait", req1_wait_request, 1'b0);
        checkOutput("t3_r0_wait", req0_wait_request, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        checkOutput("t3_mread", master_read, 1'b0);
        checkOutput("t3_grant", grant, 2'b00);
        checkOutput("t3_busy", busy, 1'b0);
        checkOutput("t3_r1_wait_after", req1_wait_request, 1'b1);
        // Last-served is still req0, so req1 must win this tie.
        applyStimulus(1'b1, 32'h2200, 8'd1, 1'b1, 32'h3200, 8'd1);
        step();
        checkOutput("t3_rr_grant", grant, 2'b10);
        checkOutput("t3_rr_addr", master_address, 32'h3200);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        step();
        sendBurst(1, 1, 32'hE000_0000);
        checkOutput("t3_rr_end_busy", busy, 1'b0);

        // Stray beat in IDLE.
        checkOutput("t4_perr_before", protocol_error, 1'b0);
        master_read_data = 32'hDEAD_BEEF;
        master_read_data_valid = 1'b1;
        #1;
        checkOutput("t4_r0_valid", req0_read_data_valid, 1'b0);
        checkOutput("t4_r1_valid", req1_read_data_valid, 1'b0);
        step();
        master_read_data_valid = 1'b0;
        #1;
        checkOutput("t4_perr_set", protocol_error, 1'b1);
        step();
        step();
        checkOutput("t4_perr_held", protocol_error, 1'b1);

        // Reset in the middle of an 8-beat burst.
        rst = 1'b1;
        #1;
        checkOutput("t5_perr_cleared", protocol_error, 1'b0);
        step();
        rst = 1'b0;
        step();
        applyStimulus(1'b1, 32'h4000, 8'd8, 1'b0, 32'd0, 8'd0);
        step();
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        step();
        sendBurst(0, 3, 32'hF000_0000);
        rst = 1'b1;
        master_read_data = 32'h0000_0055;
        master_read_data_valid = 1'b1;
        #1;
        checkOutput("t5_rst_mread", master_read, 1'b0);
        checkOutput("t5_rst_grant", grant, 2'b00);
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_perr", protocol_error, 1'b0);
        checkOutput("t5_rst_r0_wait", req0_wait_request, 1'b1);
        checkOutput("t5_rst_r1_wait", req1_wait_request, 1'b1);
        checkOutput("t5_rst_r0_valid", req0_read_data_valid, 1'b0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("t5_stray_r0_valid", req0_read_data_valid, 1'b0);
        step();
        master_read_data_valid = 1'b0;
        #1;
        checkOutput("t5_stray_perr", protocol_error, 1'b1);
        checkOutput("t5_stray_busy", busy, 1'b0);
        applyStimulus(1'b1, 32'h5000, 8'd2, 1'b0, 32'd0, 8'd0);
        step();
        checkOutput("t5_fresh_grant", grant, 2'b01);
        checkOutput("t5_fresh_addr", master_address, 32'h5000);
        checkOutput("t5_fresh_count", master_burst_count, 8'd2);
        checkOutput("t5_fresh_mread", master_read, 1'b1);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        step();
        sendBurst(0, 2, 32'h6000_0000);
        checkOutput("t5_fresh_end_busy", busy, 1'b0);

        step();
        checkOutput("q0_drained", q0.size(), 32'd0);
        checkOutput("q1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
